jt900h_memctl: RTL and testbench

Memory bus controller placed directly downstream of the jt900h CPU core's RAM port. It turns CPU word/byte requests into a handshaked external memory access with programmable wait states, a bus timeout and a single-word read cache, and it returns a one-cycle `cpu_rdy` pulse to the core. It replaces the zero-latency array model used at top level, so the core can run against real SDRAM/ROM arbiters.

---
 rtl/jt900h_memctl.sv | 178 +++++++++++++++++
 tb/tb_jt900h_memctl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt900h_memctl.sv
// jt900h memory bus controller: turns CPU word/byte requests into a handshaked
// memory access with wait states, a bus timeout and a one-word read cache.
module jt900h_memctl #(
  parameter int WAIT_ST = 1,
  parameter int TMO_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [23:0] cpu_addr,
  input  logic [1:0]  cpu_we,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_rdy,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  output logic [1:0]  mem_we,
  output logic        mem_cs,
  input  logic        mem_ok,
  output logic        bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_ST);
  localparam bit         NO_WAIT   = (WAIT_ST == 0);

  state_t             state_q, state_d;
  logic [3:0]         wait_cnt_q, wait_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [22:0]        addr_q, addr_d;
  logic [1:0]         we_q, we_d;
  logic [15:0]        din_q, din_d;
  logic [15:0]        dout_q, dout_d;
  logic               rdy_q, rdy_d;
  logic               cs_q, cs_d;
  logic [1:0]         mem_we_q, mem_we_d;
  logic               err_q, err_d;
  logic               cache_vld_q, cache_vld_d;
  logic [22:0]        cache_tag_q, cache_tag_d;
  logic [15:0]        cache_data_q, cache_data_d;

  // Byte lane select is meaningless on a 16-bit word bus.
  logic addr_lsb_unused;
  assign addr_lsb_unused = cpu_addr[0];

  logic cache_hit;
  assign cache_hit = (cpu_we == 2'b00) && cache_vld_q && (cache_tag_q == cpu_addr[23:1]);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    din_d        = din_q;
    dout_d       = dout_q;
    err_d        = err_q;
    cache_vld_d  = cache_vld_q;
    cache_tag_d  = cache_tag_q;
    cache_data_d = cache_data_q;
    rdy_d        = 1'b0;
    cs_d         = 1'b0;
    mem_we_d     = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (cache_hit) begin
            dout_d  = cache_data_q;
            rdy_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d     = cpu_addr[23:1];
            we_d       = cpu_we;
            din_d      = cpu_din;
            wait_cnt_d = WAIT_INIT;
            tmo_cnt_d  = '0;
            if (NO_WAIT) begin
              cs_d     = 1'b1;
              mem_we_d = cpu_we;
              state_d  = S_ACCESS;
            end else begin
              state_d  = S_WAIT;
            end
          end
        end
      end

      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q <= 4'd1) begin
          cs_d     = 1'b1;
          mem_we_d = we_q;
          state_d  = S_ACCESS;
        end
      end

      S_ACCESS: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (mem_ok) begin
          rdy_d   = 1'b1;
          state_d = S_DONE;
          if (we_q == 2'b00) begin
            dout_d       = mem_dout;
            cache_vld_d  = 1'b1;
            cache_tag_d  = addr_q;
            cache_data_d = mem_dout;
          end else if (cache_vld_q && cache_tag_q == addr_q) begin
            // Keep the cached word coherent with the bytes just written.
            if (we_q[0]) cache_data_d[7:0]  = din_q[7:0];
            if (we_q[1]) cache_data_d[15:8] = din_q[15:8];
          end
        end else if (tmo_cnt_q == '1) begin
          dout_d  = 16'hFFFF;
          err_d   = 1'b1;
          rdy_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cs_d     = 1'b1;
          mem_we_d = we_q;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      addr_q      <= '0;
      we_q        <= '0;
      din_q       <= '0;
      dout_q      <= '0;
      rdy_q       <= 1'b0;
      cs_q        <= 1'b0;
      mem_we_q    <= '0;
      err_q       <= 1'b0;
      cache_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      din_q       <= din_d;
      dout_q      <= dout_d;
      rdy_q       <= rdy_d;
      cs_q        <= cs_d;
      mem_we_q    <= mem_we_d;
      err_q       <= err_d;
      cache_vld_q <= cache_vld_d;
    end
  end

  // NOTE: cache tag/data are plain storage qualified by cache_vld_q, so they carry no reset.
  always_ff @(posedge clk) begin
    cache_tag_q  <= cache_tag_d;
    cache_data_q <= cache_data_d;
  end

  assign cpu_dout = dout_q;
  assign cpu_rdy  = rdy_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign mem_we   = mem_we_q;
  assign mem_cs   = cs_q;
  assign bus_err  = err_q;

endmodule

// File: tb/tb_jt900h_memctl.sv
// Bench for jt900h_memctl: a transaction-level cache/timing model predicts every
// output per cycle, plus literal checks on latency, data and strobe counts.
module tb_jt900h_memctl;

  localparam int WS    = 1;
  localparam int TMO_W = 3;
  localparam int TMO_N = 1 << TMO_W;
  localparam int INF   = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [23:0] cpu_addr;
  logic [1:0]  cpu_we;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_rdy;
  logic [22:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic [1:0]  mem_we;
  logic        mem_cs;
  logic        mem_ok;
  logic        bus_err;

  always #5 clk = ~clk;

  jt900h_memctl #(.WAIT_ST(WS), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_rdy(cpu_rdy), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_we(mem_we), .mem_cs(mem_cs),
    .mem_ok(mem_ok), .bus_err(bus_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External memory and its acknowledge behaviour.
  logic [15:0] tb_mem [0:1023];
  int ok_delay = 0;
  bit hold_ok  = 1'b0;
  int cs_run   = 0;

  initial begin
    mem_ok   = 1'b0;
    mem_dout = 16'h5A5A;
    forever begin
      @(posedge clk);
      #2;
      if (mem_cs === 1'b1) begin
        mem_ok = hold_ok || (cs_run == ok_delay);
        cs_run++;
      end else begin
        cs_run = 0;
        mem_ok = hold_ok;
      end
      mem_dout = mem_ok ? tb_mem[mem_addr[9:0]] : 16'h5A5A;
    end
  end

  always @(negedge clk) begin
    if (mem_cs === 1'b1 && mem_ok && mem_we != 2'b00) begin
      if (mem_we[0]) tb_mem[mem_addr[9:0]][7:0]  = mem_din[7:0];
      if (mem_we[1]) tb_mem[mem_addr[9:0]][15:8] = mem_din[15:8];
    end
  end

  // Model state: one-word cache plus the expected output schedule.
  bit          c_vld = 1'b0;
  logic [22:0] c_tag = '0;
  logic [15:0] c_data = '0;
  int cs_from = 0, cs_to = 0, rdy_at = -1;
  int err_set_at = INF, err_clr_at = INF;
  int dout_at = 0, rst_from = 0, rst_to = 0;
  logic [15:0] dout_old = '0, dout_new = '0;
  logic [1:0]  tx_we = '0;
  logic [22:0] tx_waddr = '0;
  logic [15:0] tx_din = '0;
  int tx_n = 0;

  // Observations gathered per transaction.
  bit mon_en = 1'b0;
  bit cs_prev = 1'b0;
  int cs_cnt = 0, rdy_cnt = 0, cs_rise = -1, rdy_seen = -1;
  logic [22:0] seen_addr = '0;
  logic [1:0]  seen_we = '0;
  logic [15:0] seen_din = '0;

  always @(negedge clk) begin : cmp
    logic exp_cs, exp_rdy, exp_err;
    logic [15:0] exp_dout;
    if (mon_en) begin
      exp_cs   = (cyc >= cs_from) && (cyc < cs_to);
      exp_rdy  = (cyc == rdy_at);
      exp_err  = (cyc >= err_set_at) && (cyc < err_clr_at);
      exp_dout = (cyc >= dout_at) ? dout_new : dout_old;
      check("mem_cs", mem_cs, exp_cs);
      check("cpu_rdy", cpu_rdy, exp_rdy);
      check("mem_we", mem_we, exp_cs ? tx_we : 2'b00);
      check("bus_err", bus_err, exp_err);
      check("cpu_dout", cpu_dout, exp_dout);
      if (exp_cs) begin
        check("mem_addr", mem_addr, tx_waddr);
        check("mem_din", mem_din, tx_din);
      end
      if (cyc >= rst_from && cyc < rst_to) begin
        check("rst_mem_addr", mem_addr, 23'd0);
        check("rst_mem_din", mem_din, 16'd0);
      end
      if (mem_cs === 1'b1) begin
        if (!cs_prev) cs_rise = cyc;
        cs_cnt++;
        seen_addr = mem_addr;
        seen_we   = mem_we;
        seen_din  = mem_din;
      end
      if (cpu_rdy === 1'b1) begin
        rdy_cnt++;
        rdy_seen = cyc;
      end
      cs_prev = (mem_cs === 1'b1);
    end
  end

  // Present a request (called #1 after an edge) and schedule its expected outputs.
  task automatic start_req(input logic [23:0] addr, input logic [1:0] we,
                           input logic [15:0] din, input int d, input bit hold);
    logic [22:0] wa;
    logic [15:0] cur;
    bit hit, tmo;
    int n, e;
    wa  = addr[23:1];
    cur = (cyc >= dout_at) ? dout_new : dout_old;
    tx_n = cyc;
    e    = cyc + 1;
    cs_cnt = 0; rdy_cnt = 0; cs_rise = -1; rdy_seen = -1;
    ok_delay = d;
    hold_ok  = hold;
    cpu_req = 1'b1; cpu_addr = addr; cpu_we = we; cpu_din = din;
    tx_we = we; tx_waddr = wa; tx_din = din;
    hit = (we == 2'b00) && c_vld && (c_tag == wa);
    dout_old = cur;
    dout_new = cur;
    if (hit) begin
      cs_from  = 0;
      cs_to    = 0;
      rdy_at   = e;
      dout_new = c_data;
    end else begin
      tmo = !hold && (d >= TMO_N);
      n   = hold ? 1 : (tmo ? TMO_N : d + 1);
      cs_from = e + WS;
      cs_to   = cs_from + n;
      rdy_at  = cs_to;
      if (tmo) begin
        dout_new = 16'hFFFF;
        if (err_set_at == INF) err_set_at = rdy_at;
      end else if (we == 2'b00) begin
        dout_new = tb_mem[wa[9:0]];
        c_vld = 1'b1; c_tag = wa; c_data = dout_new;
      end else if (c_vld && c_tag == wa) begin
        if (we[0]) c_data[7:0]  = din[7:0];
        if (we[1]) c_data[15:8] = din[15:8];
      end
    end
    dout_at = rdy_at;
  endtask

  // Full transaction; req stays high through the DONE edge to show it is ignored.
  task automatic do_req(input logic [23:0] addr, input logic [1:0] we,
                        input logic [15:0] din, input int d, input bit hold);
    start_req(addr, we, din, d, hold);
    while (cyc < rdy_at + 1) begin
      @(posedge clk);
      #1;
    end
    cpu_req = 1'b0;
    hold_ok = 1'b0;
  endtask

  task automatic reset_mid(input logic [23:0] addr);
    logic [15:0] cur;
    int r;
    start_req(addr, 2'b00, 16'h0000, 99, 1'b0);
    while (cyc < cs_from + 2) begin
      @(posedge clk);
      #1;
    end
    cur = (cyc >= dout_at) ? dout_new : dout_old;
    rst = 1'b0;
    cpu_req = 1'b0;
    r = cyc + 1;
    cs_to = r; rdy_at = -1; err_clr_at = r;
    dout_old = cur; dout_new = 16'h0000; dout_at = r;
    c_vld = 1'b0;
    rst_from = r; rst_to = r + 2;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    err_set_at = INF;
    err_clr_at = INF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) tb_mem[i] = 16'(i * 7 + 3);
    tb_mem[10'h080] = 16'hBEEF;
    tb_mem[10'h200] = 16'h55AA;
    tb_mem[10'h280] = 16'h0F0F;
    rst = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_we = '0; cpu_din = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;
    check("reset_rdy", cpu_rdy, 1'b0);
    check("reset_cs", mem_cs, 1'b0);
    check("reset_err", bus_err, 1'b0);
    check("reset_dout", cpu_dout, 16'h0000);
    check("reset_addr", mem_addr, 23'h000000);
    check("reset_din", mem_din, 16'h0000);
    check("reset_we", mem_we, 2'b00);

    do_req(24'h000100, 2'b00, 16'h0000, 0, 1'b0);
    check("miss_latency", rdy_seen - tx_n, 3);
    check("miss_cs_rise", cs_rise - tx_n, 2);
    check("miss_dout", cpu_dout, 16'hBEEF);

    do_req(24'h000100, 2'b00, 16'h0000, 0, 1'b0);
    check("hit_latency", rdy_seen - tx_n, 1);
    check("hit_no_cs", cs_cnt, 0);
    check("hit_dout", cpu_dout, 16'hBEEF);

    do_req(24'h000100, 2'b01, 16'h1234, 0, 1'b0);
    check("wr_mem_we", seen_we, 2'b01);
    check("wr_mem_din", seen_din, 16'h1234);

    do_req(24'h000101, 2'b00, 16'h0000, 0, 1'b0);
    check("odd_hit_latency", rdy_seen - tx_n, 1);
    check("merge_dout", cpu_dout, 16'hBE34);

    do_req(24'h000200, 2'b11, 16'hCAFE, 2, 1'b0);
    check("wr_other_cs", cs_cnt, 3);

    do_req(24'h000500, 2'b00, 16'h0000, 5, 1'b0);
    check("slow_cs_len", cs_cnt, 6);
    check("slow_one_rdy", rdy_cnt, 1);
    check("slow_dout", cpu_dout, 16'h0F0F);

    do_req(24'h000100, 2'b00, 16'h0000, 0, 1'b0);
    check("refill_latency", rdy_seen - tx_n, 3);
    check("refill_dout", cpu_dout, 16'hBE34);

    do_req(24'h000300, 2'b00, 16'h0000, 99, 1'b0);
    check("tmo_rdy_after_cs", rdy_seen - cs_rise, 8);
    check("tmo_dout", cpu_dout, 16'hFFFF);
    check("tmo_err", bus_err, 1'b1);

    do_req(24'h000100, 2'b00, 16'h0000, 0, 1'b0);
    check("post_tmo_hit", rdy_seen - tx_n, 1);
    check("post_tmo_dout", cpu_dout, 16'hBE34);

    do_req(24'h000400, 2'b00, 16'h0000, 0, 1'b1);
    check("hold_ok_latency", rdy_seen - tx_n, 3);
    check("hold_ok_dout", cpu_dout, 16'h55AA);
    check("err_sticky", bus_err, 1'b1);

    do_req(24'h000100, 2'b00, 16'h0000, 0, 1'b0);
    reset_mid(24'h000600);
    check("rst_no_rdy", rdy_cnt, 0);
    check("rst_cs_low", mem_cs, 1'b0);
    check("rst_err_clr", bus_err, 1'b0);

    do_req(24'h000101, 2'b00, 16'h0000, 0, 1'b0);
    check("inval_miss_cs", cs_cnt, 1);
    check("odd_mem_addr", seen_addr, 23'h000080);
    check("inval_dout", cpu_dout, 16'hBE34);

    do_req(24'h000100, 2'b10, 16'hAB00, 0, 1'b0);
    do_req(24'h000100, 2'b00, 16'h0000, 0, 1'b0);
    check("hi_merge_latency", rdy_seen - tx_n, 1);
    check("hi_merge_dout", cpu_dout, 16'hAB34);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
